// File: rtl/axi_common_types_pkg.sv
// Shared AXI widths, burst/response encodings and the bytes-per-beat helper
// used by the S6 memory responder.
package axi_common_types_pkg;

  localparam int AXI_LEN_W   = 4;
  localparam int AXI_SIZE_W  = 3;
  localparam int AXI_BURST_W = 2;
  localparam int AXI_RESP_W  = 2;

  typedef enum logic [AXI_BURST_W-1:0] {
    BURST_FIXED = 2'b00,
    BURST_INCR  = 2'b01,
    BURST_WRAP  = 2'b10,
    BURST_RSVD  = 2'b11
  } axi_burst_e;

  typedef enum logic [AXI_RESP_W-1:0] {
    RESP_OKAY   = 2'b00,
    RESP_EXOKAY = 2'b01,
    RESP_SLVERR = 2'b10,
    RESP_DECERR = 2'b11
  } axi_resp_e;

  // log2 of the bus width in bytes; only 32- and 64-bit buses are supported.
  function automatic logic [2:0] bytes_log2(input int data_width);
    return (data_width == 64) ? 3'd3 : 3'd2;
  endfunction

endpackage

// File: rtl/axi_burst_addr_gen.sv
// Combinational next-beat address and per-beat legality for one AXI channel.
module axi_burst_addr_gen
  import axi_common_types_pkg::*;
#(
  parameter int                    ADDR_WIDTH = 32,
  parameter int                    DATA_WIDTH = 32,
  parameter int                    MEM_DEPTH  = 1024,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = 32'h6000_0000
) (
  input  logic [ADDR_WIDTH-1:0]  addr,
  input  logic [AXI_LEN_W-1:0]   len,
  input  logic [AXI_SIZE_W-1:0]  size,
  input  logic [AXI_BURST_W-1:0] burst,
  output logic [ADDR_WIDTH-1:0]  next_addr,
  output logic                   beat_err
);

  typedef logic [ADDR_WIDTH:0] wide_t;

  localparam logic [2:0] MAX_SIZE = bytes_log2(DATA_WIDTH);
  localparam wide_t      WIN_LO   = {1'b0, BASE_ADDR};
  localparam wide_t      WIN_HI   = WIN_LO + wide_t'(MEM_DEPTH * (DATA_WIDTH / 8));

  logic [ADDR_WIDTH-1:0] step;
  logic [ADDR_WIDTH-1:0] wrap_mask;
  logic [ADDR_WIDTH-1:0] incr_addr;
  logic                  wrap_len_ok;
  logic                  window_ok;

  // NOTE: every output of a combinational block gets a value on every path
  // (defaults first), otherwise synthesis infers a latch to hold the old value.
  always_comb begin
    next_addr   = addr;
    step        = ADDR_WIDTH'(1) << size;
    wrap_mask   = ((ADDR_WIDTH'(len) + ADDR_WIDTH'(1)) << size) - ADDR_WIDTH'(1);
    incr_addr   = addr + step;
    wrap_len_ok = len inside {4'd1, 4'd3, 4'd7, 4'd15};
    window_ok   = ({1'b0, addr} >= WIN_LO) && ({1'b0, addr} < WIN_HI);

    case (axi_burst_e'(burst))
      BURST_FIXED: next_addr = addr;
      // Container is power-of-two sized, so wrapping keeps the upper bits.
      BURST_WRAP:  next_addr = wrap_len_ok ? ((addr & ~wrap_mask) | (incr_addr & wrap_mask))
                                           : incr_addr;
      default:     next_addr = incr_addr;
    endcase

    beat_err = (burst == BURST_RSVD)
            || ((burst == BURST_WRAP) && !wrap_len_ok)
            || (size > MAX_SIZE)
            || !window_ok;
  end

endmodule

// File: rtl/axi_s6_mem_responder.sv
// AXI slave memory model for the interconnect S6 port: one outstanding write,
// one outstanding read. Optional LFSR backpressure: AXI_S6_MEM_BACKPRESSURE_EN.
module axi_s6_mem_responder
  import axi_common_types_pkg::*;
#(
  parameter int                    ID_WIDTH   = 4,
  parameter int                    ADDR_WIDTH = 32,
  parameter int                    DATA_WIDTH = 32,
  parameter int                    MEM_DEPTH  = 1024,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = 32'h6000_0000
) (
`ifdef AXI_S6_MEM_BACKPRESSURE_EN
  input  logic                    S6_BP_EN,
`endif
  input  logic                    ACLK,
  input  logic                    ARESET,
  input  logic [ID_WIDTH-1:0]     S6_AWID,
  input  logic [ADDR_WIDTH-1:0]   S6_AWADDR,
  input  logic [3:0]              S6_AWLEN,
  input  logic [2:0]              S6_AWSIZE,
  input  logic [1:0]              S6_AWBURST,
  input  logic                    S6_AWVALID,
  output logic                    S6_AWREADY,
  input  logic [DATA_WIDTH-1:0]   S6_WDATA,
  input  logic [DATA_WIDTH/8-1:0] S6_WSTRB,
  input  logic                    S6_WLAST,
  input  logic                    S6_WVALID,
  output logic                    S6_WREADY,
  output logic [ID_WIDTH-1:0]     S6_BID,
  output logic [1:0]              S6_BRESP,
  output logic                    S6_BVALID,
  input  logic                    S6_BREADY,
  input  logic [ID_WIDTH-1:0]     S6_ARID,
  input  logic [ADDR_WIDTH-1:0]   S6_ARADDR,
  input  logic [3:0]              S6_ARLEN,
  input  logic [2:0]              S6_ARSIZE,
  input  logic [1:0]              S6_ARBURST,
  input  logic                    S6_ARVALID,
  output logic                    S6_ARREADY,
  output logic [ID_WIDTH-1:0]     S6_RID,
  output logic [DATA_WIDTH-1:0]   S6_RDATA,
  output logic [1:0]              S6_RRESP,
  output logic                    S6_RLAST,
  output logic                    S6_RVALID,
  input  logic                    S6_RREADY
);

  localparam int STRB_W = DATA_WIDTH / 8;
  localparam int IDX_W  = $clog2(MEM_DEPTH);
  localparam int LSB    = int'(bytes_log2(DATA_WIDTH));

  localparam logic [1:0] W_IDLE = 2'd0;
  localparam logic [1:0] W_DATA = 2'd1;
  localparam logic [1:0] W_RESP = 2'd2;
  localparam logic [0:0] R_IDLE = 1'b0;
  localparam logic [0:0] R_DATA = 1'b1;

  logic bp_stall;

`ifdef AXI_S6_MEM_BACKPRESSURE_EN
  logic [15:0] lfsr;

  // NOTE: clocked state uses non-blocking assignments so every flop samples
  // the pre-edge value of its inputs, independent of block ordering.
  always_ff @(posedge ACLK) begin
    if (ARESET) lfsr <= 16'hACE1;
    else        lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
  end

  assign bp_stall = S6_BP_EN && (lfsr[1:0] == 2'b00);
`else
  assign bp_stall = 1'b0;
`endif

  logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

  // ---------------- write channel ----------------
  logic [1:0]            w_state;
  logic [ID_WIDTH-1:0]   aw_id;
  logic [ADDR_WIDTH-1:0] aw_addr;
  logic [3:0]            aw_len;
  logic [2:0]            aw_size;
  logic [1:0]            aw_burst;
  logic [3:0]            w_beat;
  logic                  w_err;
  logic [ADDR_WIDTH-1:0] w_next_addr;
  logic                  w_beat_err;
  logic                  w_hs;
  logic                  w_last_beat;
  logic                  mem_we;
  logic [IDX_W-1:0]      wr_idx;

  axi_burst_addr_gen #(
    .ADDR_WIDTH(ADDR_WIDTH), .DATA_WIDTH(DATA_WIDTH),
    .MEM_DEPTH(MEM_DEPTH),   .BASE_ADDR(BASE_ADDR)
  ) u_w_addr_gen (
    .addr(aw_addr), .len(aw_len), .size(aw_size), .burst(aw_burst),
    .next_addr(w_next_addr), .beat_err(w_beat_err)
  );

  assign S6_AWREADY  = (w_state == W_IDLE) && !bp_stall;
  assign S6_WREADY   = (w_state == W_DATA) && !bp_stall;
  assign S6_BVALID   = (w_state == W_RESP);
  assign S6_BID      = aw_id;
  assign S6_BRESP    = w_err ? RESP_SLVERR : RESP_OKAY;
  assign w_hs        = S6_WVALID && S6_WREADY;
  assign w_last_beat = (w_beat == aw_len);
  assign mem_we      = w_hs && !w_beat_err && !ARESET;
  assign wr_idx      = IDX_W'((aw_addr - BASE_ADDR) >> LSB);

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      w_state  <= W_IDLE;
      aw_id    <= '0;
      aw_addr  <= '0;
      aw_len   <= '0;
      aw_size  <= '0;
      aw_burst <= '0;
      w_beat   <= '0;
      w_err    <= 1'b0;
    end else begin
      case (w_state)
        W_IDLE: if (S6_AWVALID && S6_AWREADY) begin
          aw_id    <= S6_AWID;
          aw_addr  <= S6_AWADDR;
          aw_len   <= S6_AWLEN;
          aw_size  <= S6_AWSIZE;
          aw_burst <= S6_AWBURST;
          w_beat   <= '0;
          w_err    <= 1'b0;
          w_state  <= W_DATA;
        end
        W_DATA: if (w_hs) begin
          // Beat count ends the burst; WLAST is only checked against it.
          aw_addr <= w_next_addr;
          w_beat  <= w_beat + 4'd1;
          if (w_beat_err || (S6_WLAST != w_last_beat)) w_err <= 1'b1;
          if (w_last_beat) w_state <= W_RESP;
        end
        W_RESP: if (S6_BREADY) w_state <= W_IDLE;
        default: w_state <= W_IDLE;
      endcase
    end
  end

  // NOTE: the storage array is deliberately not reset; contents survive
  // ARESET and the array maps onto plain RAM.
  always_ff @(posedge ACLK) begin
    if (mem_we) begin
      for (int b = 0; b < STRB_W; b++) begin
        if (S6_WSTRB[b]) mem[wr_idx][8*b +: 8] <= S6_WDATA[8*b +: 8];
      end
    end
  end

  // ---------------- read channel ----------------
  logic [0:0]            r_state;
  logic [ID_WIDTH-1:0]   ar_id;
  logic [ADDR_WIDTH-1:0] ar_addr;
  logic [3:0]            ar_len;
  logic [2:0]            ar_size;
  logic [1:0]            ar_burst;
  logic [3:0]            r_beat;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic [1:0]            rresp_q;
  logic                  rlast_q;
  logic                  rvalid_q;
  logic [ADDR_WIDTH-1:0] rg_addr;
  logic [3:0]            rg_len;
  logic [2:0]            rg_size;
  logic [1:0]            rg_burst;
  logic [3:0]            rg_beat;
  logic [ADDR_WIDTH-1:0] r_next_addr;
  logic                  r_beat_err;
  logic [IDX_W-1:0]      rd_idx;
  logic                  ar_hs;
  logic                  r_hs;
  logic                  r_launch;

  // In idle the generator looks at the AR bus so beat 0 launches on the handshake.
  assign rg_addr  = (r_state == R_IDLE) ? S6_ARADDR  : ar_addr;
  assign rg_len   = (r_state == R_IDLE) ? S6_ARLEN   : ar_len;
  assign rg_size  = (r_state == R_IDLE) ? S6_ARSIZE  : ar_size;
  assign rg_burst = (r_state == R_IDLE) ? S6_ARBURST : ar_burst;
  assign rg_beat  = (r_state == R_IDLE) ? 4'd0       : r_beat;

  axi_burst_addr_gen #(
    .ADDR_WIDTH(ADDR_WIDTH), .DATA_WIDTH(DATA_WIDTH),
    .MEM_DEPTH(MEM_DEPTH),   .BASE_ADDR(BASE_ADDR)
  ) u_r_addr_gen (
    .addr(rg_addr), .len(rg_len), .size(rg_size), .burst(rg_burst),
    .next_addr(r_next_addr), .beat_err(r_beat_err)
  );

  assign S6_ARREADY = (r_state == R_IDLE) && !bp_stall;
  assign S6_RID     = ar_id;
  assign S6_RDATA   = rdata_q;
  assign S6_RRESP   = rresp_q;
  assign S6_RLAST   = rlast_q;
  assign S6_RVALID  = rvalid_q;
  assign rd_idx     = IDX_W'((rg_addr - BASE_ADDR) >> LSB);
  assign ar_hs      = S6_ARVALID && S6_ARREADY;
  assign r_hs       = rvalid_q && S6_RREADY;
  // A new beat goes out when the slot is empty or the current non-last beat is taken.
  assign r_launch   = ar_hs
                   || ((r_state == R_DATA) && (!rvalid_q || (r_hs && !rlast_q)) && !bp_stall);

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      r_state  <= R_IDLE;
      ar_id    <= '0;
      ar_addr  <= '0;
      ar_len   <= '0;
      ar_size  <= '0;
      ar_burst <= '0;
      r_beat   <= '0;
      rdata_q  <= '0;
      rresp_q  <= RESP_OKAY;
      rlast_q  <= 1'b0;
      rvalid_q <= 1'b0;
    end else begin
      if (ar_hs) begin
        ar_id    <= S6_ARID;
        ar_len   <= S6_ARLEN;
        ar_size  <= S6_ARSIZE;
        ar_burst <= S6_ARBURST;
        r_state  <= R_DATA;
      end
      if (r_launch) begin
        rvalid_q <= 1'b1;
        rdata_q  <= r_beat_err ? '0 : mem[rd_idx];
        rresp_q  <= r_beat_err ? RESP_SLVERR : RESP_OKAY;
        rlast_q  <= (rg_beat == rg_len);
        ar_addr  <= r_next_addr;
        r_beat   <= rg_beat + 4'd1;
      end else if (r_hs) begin
        rvalid_q <= 1'b0;
        if (rlast_q) begin
          rlast_q <= 1'b0;
          r_state <= R_IDLE;
        end
      end
    end
  end

endmodule

// File: doc/axi_s6_mem_responder.md
Name: axi_s6_mem_responder

Overview:
- Synthesizable AXI slave memory model attached directly downstream of the interconnect's Slave 6 port.
- Consumes AW/W/AR requests routed to S6 and produces B/R responses.
- Used as the S6 endpoint in integration benches, and as a reference responder alongside the S6 UVM agent.
- Write and read paths are independent and share one register-array memory.

Parameters:
- ID_WIDTH, 4, AWID/BID/ARID/RID width.
- ADDR_WIDTH, 32, address width.
- DATA_WIDTH, 32, data width; must be 32 or 64.
- MEM_DEPTH, 1024, number of DATA_WIDTH words.
- BASE_ADDR, 32'h6000_0000, byte address of word 0.

Ports:
- ACLK  in  1  clock.
- ARESET  in  1  synchronous active-high reset.
- S6_AWID/AWADDR/AWLEN/AWSIZE/AWBURST  in  ID/ADDR/4/3/2  write address.
- S6_AWVALID  in  1; S6_AWREADY  out  1.
- S6_WDATA  in  DATA; S6_WSTRB  in  DATA/8; S6_WLAST, S6_WVALID  in  1; S6_WREADY  out  1.
- S6_BID  out  ID; S6_BRESP  out  2; S6_BVALID  out  1; S6_BREADY  in  1.
- S6_ARID/ARADDR/ARLEN/ARSIZE/ARBURST  in  ID/ADDR/4/3/2  read address.
- S6_ARVALID  in  1; S6_ARREADY  out  1.
- S6_RID  out  ID; S6_RDATA  out  DATA; S6_RRESP  out  2; S6_RLAST, S6_RVALID  out  1; S6_RREADY  in  1.
- LOCK/CACHE/PROT/QOS/REGION/USER inputs are not ported; USER outputs are not driven.

Behaviour:
- Clocking and reset: one clock, ACLK; reset ARESET is synchronous and active-high.
- Reset values: AWREADY=1, ARREADY=1, WREADY=0, BVALID=0, RVALID=0, RLAST=0, BID/RID/BRESP/RRESP/RDATA=0.
- Reset mid-burst aborts the transaction with no response. Memory contents are not cleared.

Write FSM:
- W_IDLE: AWREADY=1. On AW handshake, latch id/addr/len/size/burst, clear beat counter and error flag, go to W_DATA.
- W_DATA: AWREADY=0, WREADY=1.
  - Each W handshake writes the bytes enabled by WSTRB at the current address.
  - Address then advances per burst type.
  - When the beat counter reaches len, go to W_RESP.
  - Beat count is authoritative. WLAST must equal (beat==len); a mismatch sets the error flag.
- W_RESP: WREADY=0, BVALID=1, BID=latched id, BRESP = error ? SLVERR(2'b10) : OKAY. On BREADY go to W_IDLE.
- AWREADY returns high the cycle after the B handshake. There is one outstanding write.

Read FSM:
- R_IDLE: ARREADY=1. On AR handshake latch fields, go to R_DATA.
- R_DATA:
  - First beat RVALID=1 in cycle N+1 after the AR handshake in cycle N.
  - RDATA/RRESP/RLAST are registered and stay stable while RVALID && !RREADY.
  - On each handshake the next beat is presented in the following cycle (back-to-back at full rate).
  - RLAST=1 on beat len.
  - After the last handshake: R_IDLE, RVALID=0, ARREADY=1 the next cycle.

Address and error rules:
- FIXED: address constant. INCR: addr += 1<<size.
- WRAP: len must be 1/3/7/15. Container = (len+1)<<size, aligned down. Address wraps to the container base on overflow.
- SLVERR cases:
  - burst==2'b11;
  - WRAP with an illegal len;
  - size > log2(DATA_WIDTH/8);
  - any beat address outside [BASE_ADDR, BASE_ADDR+MEM_DEPTH*DATA_WIDTH/8).
- Per-beat effect of an error: erroring write beats are not stored. Erroring read beats return RDATA=0 with RRESP=SLVERR; other beats return OKAY.
- Memory index = (addr-BASE_ADDR) >> log2(DATA_WIDTH/8). Narrow transfers rely on WSTRB for lane selection; read data is the full word.
- Simultaneous write and read to the same word in the same cycle: read returns the pre-write data.

Optional Feature:
- Macro: AXI_S6_MEM_BACKPRESSURE_EN.
- When defined:
  - Adds input port S6_BP_EN (1 bit) and a 16-bit LFSR (seed 16'hACE1, taps 16,14,13,11) advancing every cycle.
  - While S6_BP_EN=1 and LFSR[1:0]==2'b00:
    - WREADY is forced 0 in W_DATA;
    - the next R beat is not launched (RVALID never drops once asserted);
    - AWREADY and ARREADY are forced 0 in IDLE.
- When undefined: no port, no LFSR, full-throughput behaviour as above.

Decomposition:
- axi_common_types_pkg supplies the width constants, the burst encodings (FIXED/INCR/WRAP) and resp encodings (OKAY/EXOKAY/SLVERR/DECERR).
- A local package-level function computes log2 bytes per beat.
- One sub-module, axi_burst_addr_gen: given addr/size/len/burst, produces next_addr and a beat-illegal flag. It is combinational and instantiated once per channel.

Test Plan:
- INCR write: AWADDR=0x6000_0010, AWLEN=3, AWSIZE=2, data 0x11..0x44, WSTRB=F -> BRESP=OKAY. Then an INCR read of the same burst returns 0x11,0x22,0x33,0x44 with RLAST on beat 4, first RVALID 1 cycle after AR.
- WRAP read: ARADDR=0x6000_0008, ARLEN=3, ARSIZE=2 -> beats at offsets 0x08,0x0C,0x00,0x04.
- Partial strobe: write 0xAABBCCDD WSTRB=4'b0101 over 0xFFFFFFFF -> read returns 0xFFBBFFDD.
- Out-of-window: write at BASE_ADDR+MEM_DEPTH*4-4 with AWLEN=1 -> BRESP=SLVERR, first word stored, second not. Read of AWBURST=2'b11 -> every beat SLVERR with RDATA=0.
- Backpressure: hold RREADY=0 for 5 cycles mid-burst -> RDATA/RLAST stable. WLAST asserted on beat 2 of a len=3 burst -> BRESP=SLVERR. BREADY low for 3 cycles -> BVALID held, AWREADY stays 0.
- Reset: assert ARESET during W_DATA -> next cycle AWREADY=1, WREADY=0, BVALID=0, and no B response is issued. With AXI_S6_MEM_BACKPRESSURE_EN and S6_BP_EN=1, a 16-beat read completes with correct data and RVALID never dropping unhandshaken.
